// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared control-bit struct and widths for the EX/MEM stage.
package ex_mem_pkg;
    localparam int REG_W = 5;
    typedef struct packed {
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic MemtoReg;
        logic Branch;
    } ctrl_t;
    localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/ex_mem_stage_data_ram.sv
// data_ram: single-port word RAM with synchronous read and write.
module data_ram #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register, data-memory access, branch resolve and MEM/WB register.
// Define EX_MEM_MISALIGN_CHECK_EN to flag and suppress misaligned LW/SW.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ALUResult,
    input  logic             zero,
    input  logic [31:0]      ReadData2,
    input  logic [31:0]      branch_target,
    input  logic [REG_W-1:0] rd,
    input  logic             in_valid,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             Branch,
    input  logic             stall,
    input  logic             flush,
    output logic [REG_W-1:0] exmem_rd,
    output logic             exmem_RegWrite,
    output logic [31:0]      exmem_ALUResult,
    output logic             PCSrc,
    output logic [31:0]      PCBranch,
    output logic [31:0]      wb_data,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_RegWrite,
    output logic             wb_valid,
    output logic             mem_fault
);
    ctrl_t             in_ctrl, em_ctrl;
    logic              em_valid, em_zero;
    logic [31:0]       em_alu, em_wdata, em_bt;
    logic [REG_W-1:0]  em_rd;
    logic              we, load_fault, wb_sel;
    logic [31:0]       wb_alu, ram_rdata;

    assign in_ctrl = '{RegWrite, MemRead, MemWrite, MemtoReg, Branch};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            em_valid <= 1'b0;
            em_ctrl  <= BUBBLE_CTRL;
            em_zero  <= 1'b0;
            em_alu   <= '0;
            em_wdata <= '0;
            em_bt    <= '0;
            em_rd    <= '0;
        end else if (!stall) begin
            em_valid <= in_valid;
            em_ctrl  <= in_ctrl;
            em_zero  <= zero;
            em_alu   <= ALUResult;
            em_wdata <= ReadData2;
            em_bt    <= branch_target;
            em_rd    <= rd;
        end
    end

`ifdef EX_MEM_MISALIGN_CHECK_EN
    assign mem_fault = em_valid & (em_ctrl.MemRead | em_ctrl.MemWrite) & (em_alu[1:0] != 2'b00);
`else
    assign mem_fault = 1'b0;
`endif

    assign exmem_rd        = em_rd;
    assign exmem_RegWrite  = em_ctrl.RegWrite;
    assign exmem_ALUResult = em_alu;
    assign PCSrc           = em_valid & em_ctrl.Branch & em_zero;
    assign PCBranch        = em_bt;
    assign load_fault      = mem_fault & em_ctrl.MemRead;
    // a store held by stall or caught by reset must not write on that edge
    assign we = em_valid & em_ctrl.MemWrite & ~stall & ~reset & ~mem_fault;

    data_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (em_alu[AW+1:2]),
        .wdata (em_wdata),
        .rdata (ram_rdata)
    );

    // the RAM output register doubles as the load-data half of MEM/WB
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_sel      <= 1'b0;
            wb_alu      <= '0;
            wb_rd       <= '0;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end else begin
            wb_sel      <= em_ctrl.MemtoReg & ~load_fault;
            wb_alu      <= load_fault ? '0 : em_alu;
            wb_rd       <= em_rd;
            wb_valid    <= em_valid & ~stall;
            wb_RegWrite <= em_valid & em_ctrl.RegWrite & ~stall & ~load_fault;
        end
    end

    assign wb_data = wb_sel ? ram_rdata : wb_alu;
endmodule
